// File: rtl/anc_pkg.sv
// Shared types and defaults for the ANC per-sample sequencer.
// Holds the FSM state enum plus the sample width and stage timeout defaults.
package anc_pkg;

  localparam int DATA_W             = 16;
  localparam int OVR_W_DEF          = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1500;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LP   = 3'd1,
    ST_BUF  = 3'd2,
    ST_LMS  = 3'd3,
    ST_FIR  = 3'd4,
    ST_OUT  = 3'd5
  } anc_state_t;

  // States in which the sequencer waits on a stage done and the watchdog runs.
  function automatic logic is_wait_state(input anc_state_t s);
    return (s == ST_LP) || (s == ST_LMS) || (s == ST_FIR);
  endfunction

endpackage

// File: rtl/anc_sequencer_if.sv
// Sequencer <-> datapath/I2S bundle: stage start/done strobes, FIR sample, speaker and status.
// master = the sequencer, slave = the datapath side driving dones and the sample pulse.
interface anc_sequencer_if #(
  parameter int DATA_W = anc_pkg::DATA_W,
  parameter int OVR_W  = anc_pkg::OVR_W_DEF
);

  logic                     sample_pulse_in;
  logic                     nc_on_in;
  logic                     adapt_en_in;
  logic                     lp_done_in;
  logic                     lms_done_in;
  logic                     fir_done_in;
  logic signed [DATA_W-1:0] fir_sample_in;
  logic                     lp_start_out;
  logic                     buf_write_out;
  logic                     lms_start_out;
  logic                     fir_start_out;
  logic signed [DATA_W-1:0] speaker_out;
  logic                     speaker_valid_out;
  logic                     busy_out;
  logic [OVR_W-1:0]         overrun_count_out;
  logic                     timeout_flag_out;

  modport master (
    input  sample_pulse_in, nc_on_in, adapt_en_in,
    input  lp_done_in, lms_done_in, fir_done_in, fir_sample_in,
    output lp_start_out, buf_write_out, lms_start_out, fir_start_out,
    output speaker_out, speaker_valid_out, busy_out, overrun_count_out, timeout_flag_out
  );

  modport slave (
    output sample_pulse_in, nc_on_in, adapt_en_in,
    output lp_done_in, lms_done_in, fir_done_in, fir_sample_in,
    input  lp_start_out, buf_write_out, lms_start_out, fir_start_out,
    input  speaker_out, speaker_valid_out, busy_out, overrun_count_out, timeout_flag_out
  );

endinterface

// File: rtl/anc_sequencer_stage_watchdog.sv
// Per-stage wait counter: cleared on stage entry, counts while enabled, flags expiry.
// expired is combinational and rises in the TIMEOUT_CYCLES-th cycle spent in the stage.
module stage_watchdog #(
  parameter int TIMEOUT_CYCLES = anc_pkg::TIMEOUT_CYCLES_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in || clear) begin
      wait_cnt <= '0;
    end else if (enable && !expired) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign expired = enable && (wait_cnt == CNT_LAST);

endmodule

// File: rtl/anc_sequencer.sv
// Per-sample ANC controller: LP -> buffer write -> optional LMS -> FIR -> speaker register.
// Minimum latency 8 cycles (6 without LMS); pulses arriving while busy are dropped and counted.
module anc_sequencer #(
  parameter int TIMEOUT_CYCLES = anc_pkg::TIMEOUT_CYCLES_DEF,
  parameter int DATA_W         = anc_pkg::DATA_W,
  parameter int OVR_W          = anc_pkg::OVR_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  anc_sequencer_if.master  bus
);

  import anc_pkg::*;

  localparam logic [OVR_W-1:0] OVR_MAX = {OVR_W{1'b1}};

  anc_state_t               state_q, state_d;
  logic                     lp_start_q, lp_start_d;
  logic                     buf_wr_q, buf_wr_d;
  logic                     lms_start_q, lms_start_d;
  logic                     fir_start_q, fir_start_d;
  logic                     spk_vld_q, spk_vld_d;
  logic                     busy_q;
  logic                     tmo_q, tmo_d;
  logic signed [DATA_W-1:0] spk_q, spk_d;
  logic signed [DATA_W-1:0] cap_q, cap_d;
  logic [OVR_W-1:0]         ovr_q, ovr_d;
  logic                     wd_clear, wd_enable, wd_expired;

  assign wd_enable = is_wait_state(state_q);

  stage_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    lp_start_d  = 1'b0;
    buf_wr_d    = 1'b0;
    lms_start_d = 1'b0;
    fir_start_d = 1'b0;
    spk_vld_d   = 1'b0;
    spk_d       = spk_q;
    cap_d       = cap_q;
    tmo_d       = tmo_q;
    ovr_d       = ovr_q;
    wd_clear    = 1'b0;

    if (bus.sample_pulse_in && (state_q != ST_IDLE) && (ovr_q != OVR_MAX)) begin
      ovr_d = ovr_q + 1'b1;
    end

    // A done coinciding with its own start strobe is too early and is ignored.
    case (state_q)
      ST_IDLE: begin
        if (bus.sample_pulse_in) begin
          state_d    = ST_LP;
          lp_start_d = 1'b1;
          wd_clear   = 1'b1;
        end
      end
      ST_LP: begin
        if (bus.lp_done_in && !lp_start_q) begin
          state_d  = ST_BUF;
          buf_wr_d = 1'b1;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      ST_BUF: begin
        wd_clear = 1'b1;
        if (bus.adapt_en_in) begin
          state_d     = ST_LMS;
          lms_start_d = 1'b1;
        end else begin
          state_d     = ST_FIR;
          fir_start_d = 1'b1;
        end
      end
      ST_LMS: begin
        if (bus.lms_done_in && !lms_start_q) begin
          state_d     = ST_FIR;
          fir_start_d = 1'b1;
          wd_clear    = 1'b1;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      ST_FIR: begin
        if (bus.fir_done_in && !fir_start_q) begin
          state_d = ST_OUT;
          cap_d   = bus.fir_sample_in;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      ST_OUT: begin
        spk_d     = bus.nc_on_in ? cap_q : '0;
        spk_vld_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      lp_start_q  <= 1'b0;
      buf_wr_q    <= 1'b0;
      lms_start_q <= 1'b0;
      fir_start_q <= 1'b0;
      spk_vld_q   <= 1'b0;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
      spk_q       <= '0;
      cap_q       <= '0;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      lp_start_q  <= lp_start_d;
      buf_wr_q    <= buf_wr_d;
      lms_start_q <= lms_start_d;
      fir_start_q <= fir_start_d;
      spk_vld_q   <= spk_vld_d;
      busy_q      <= (state_d != ST_IDLE);
      tmo_q       <= tmo_d;
      spk_q       <= spk_d;
      cap_q       <= cap_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.lp_start_out      = lp_start_q;
  assign bus.buf_write_out     = buf_wr_q;
  assign bus.lms_start_out     = lms_start_q;
  assign bus.fir_start_out     = fir_start_q;
  assign bus.speaker_out       = spk_q;
  assign bus.speaker_valid_out = spk_vld_q;
  assign bus.busy_out          = busy_q;
  assign bus.overrun_count_out = ovr_q;
  assign bus.timeout_flag_out  = tmo_q;

endmodule

// File: tb/tb_anc_sequencer.sv
// Bench for anc_sequencer: emulated datapath stages with programmable done delays,
// frame-level reference model for latency, start ordering, speaker value and overruns.
module tb_anc_sequencer;

  localparam int TO = 1500;
  localparam int DW = 16;
  localparam int OW = 8;
  localparam int OVR_SAT = 255;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  anc_sequencer_if #(.DATA_W(DW), .OVR_W(OW)) bus ();

  anc_sequencer #(.TIMEOUT_CYCLES(TO), .DATA_W(DW), .OVR_W(OW)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lp_dly, lms_dly, fir_dly;
  int lp_cnt = 0, lms_cnt = 0, fir_cnt = 0;
  int seq_code, vld_cnt;
  bit fir_seen;
  logic signed [DW-1:0] fir_val;
  int extra_q[$], lp_inj[$], lms_inj[$], fir_inj[$];
  logic signed [DW-1:0] exp_spk;
  int exp_ovr;
  logic exp_tmo;

  // Event codes in seq_code (octal digits): 1 LP, 2 BUF, 3 LMS, 4 FIR, 5 speaker valid.
  task automatic tick();
    @(posedge clk_in); #1;
    cyc++;
    bus.sample_pulse_in = 1'b0;
    if (bus.lp_start_out)  begin seq_code = seq_code * 8 + 1; lp_cnt  = (lp_dly  > 0) ? lp_dly  + 1 : 0; end
    if (bus.buf_write_out) seq_code = seq_code * 8 + 2;
    if (bus.lms_start_out) begin seq_code = seq_code * 8 + 3; lms_cnt = (lms_dly > 0) ? lms_dly + 1 : 0; end
    if (bus.fir_start_out) begin seq_code = seq_code * 8 + 4; fir_cnt = (fir_dly > 0) ? fir_dly + 1 : 0; fir_seen = 1'b1; end
    if (bus.speaker_valid_out) begin seq_code = seq_code * 8 + 5; vld_cnt++; end
    bus.lp_done_in = 1'b0;  if (lp_cnt  > 0) begin lp_cnt--;  if (lp_cnt  == 0) bus.lp_done_in  = 1'b1; end
    bus.lms_done_in = 1'b0; if (lms_cnt > 0) begin lms_cnt--; if (lms_cnt == 0) bus.lms_done_in = 1'b1; end
    bus.fir_done_in = 1'b0; if (fir_cnt > 0) begin fir_cnt--; if (fir_cnt == 0) bus.fir_done_in = 1'b1; end
    bus.fir_sample_in = bus.fir_done_in ? fir_val : DW'($urandom);
  endtask

  task automatic apply_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    exp_spk = '0; exp_ovr = 0; exp_tmo = 1'b0;
  endtask

  // One frame: pulse at offset 0; extras/injections are applied at the given edge offsets.
  task automatic do_frame(input int budget, output int lat, output int end_off);
    int start, n;
    seq_code = 0; vld_cnt = 0; lat = -1; end_off = -1;
    bus.sample_pulse_in = 1'b1;
    start = cyc + 1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.speaker_valid_out) lat = cyc - start;
      if (!bus.busy_out) begin end_off = cyc - start; break; end
      n = cyc + 1 - start;
      foreach (extra_q[j]) if (extra_q[j] == n) bus.sample_pulse_in = 1'b1;
      foreach (lp_inj[j])  if (lp_inj[j]  == n) bus.lp_done_in  = 1'b1;
      foreach (lms_inj[j]) if (lms_inj[j] == n) bus.lms_done_in = 1'b1;
      foreach (fir_inj[j]) if (fir_inj[j] == n) bus.fir_done_in = 1'b1;
    end
  endtask

  // Each wait stage lasts done-delay+1 edges; BUF and OUT one edge each.
  function automatic int exp_lat(input bit adapt);
    return (lp_dly + 1) + 1 + (adapt ? lms_dly + 1 : 0) + (fir_dly + 1) + 1;
  endfunction

  function automatic int drops(input int frame_len);
    int d = 0;
    foreach (extra_q[j]) if (extra_q[j] >= 1 && extra_q[j] <= frame_len) d++;
    return d;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > OVR_SAT) ? OVR_SAT : a + b;
  endfunction

  task automatic clear_sched();
    extra_q.delete(); lp_inj.delete(); lms_inj.delete(); fir_inj.delete();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({bus.lp_start_out, bus.buf_write_out, bus.lms_start_out, bus.fir_start_out, bus.speaker_valid_out} !== 5'b0) begin
      n_bad++; $display("FAIL reset_strobes got %b want 00000", {bus.lp_start_out, bus.buf_write_out, bus.lms_start_out, bus.fir_start_out, bus.speaker_valid_out});
    end
    n_cmp++;
    if (bus.speaker_out !== '0) begin n_bad++; $display("FAIL reset_speaker got %0d want 0", bus.speaker_out); end
    n_cmp++;
    if ({bus.busy_out, bus.timeout_flag_out, bus.overrun_count_out} !== '0) begin
      n_bad++; $display("FAIL reset_status busy=%b tmo=%b ovr=%0d want all 0", bus.busy_out, bus.timeout_flag_out, bus.overrun_count_out);
    end
    rst_in = 1'b0;
    exp_spk = '0; exp_ovr = 0; exp_tmo = 1'b0;
    tick();
    n_cmp++;
    if (bus.busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_idle busy got %b want 0", bus.busy_out); end
  endtask

  task automatic run_basic(input string tag, input bit adapt, input bit nc, input int d, input logic signed [DW-1:0] val);
    int lat, e;
    clear_sched();
    lp_dly = d; lms_dly = d; fir_dly = d; fir_val = val;
    bus.adapt_en_in = adapt; bus.nc_on_in = nc;
    do_frame(200, lat, e);
    exp_spk = nc ? val : '0;
    n_cmp++;
    if (seq_code !== (adapt ? 'o12345 : 'o1245)) begin n_bad++; $display("FAIL %s_order got %o want %o", tag, seq_code, adapt ? 'o12345 : 'o1245); end
    n_cmp++;
    if (lat !== exp_lat(adapt)) begin n_bad++; $display("FAIL %s_latency got %0d want %0d", tag, lat, exp_lat(adapt)); end
    n_cmp++;
    if (bus.speaker_out !== exp_spk) begin n_bad++; $display("FAIL %s_speaker got %0d want %0d", tag, bus.speaker_out, exp_spk); end
    tick();
    n_cmp++;
    if (vld_cnt !== 1 || bus.busy_out !== 1'b0) begin n_bad++; $display("FAIL %s_single_valid valid_count=%0d busy=%b want 1/0", tag, vld_cnt, bus.busy_out); end
  endtask

  task automatic test_adapt_on();
    run_basic("adapt_on", 1'b1, 1'b1, 3, 16'sd1234);
    run_basic("adapt_on_min", 1'b1, 1'b1, 1, 16'sd77);
  endtask

  task automatic test_adapt_off();
    run_basic("adapt_off", 1'b0, 1'b1, 3, 16'sd1234);
    run_basic("nc_off", 1'b0, 1'b0, 3, -16'sd500);
    run_basic("adapt_off_min", 1'b0, 1'b1, 1, -16'sd9);
  endtask

  task automatic test_overrun();
    int lat, e, frame_len;
    apply_reset();
    clear_sched();
    lp_dly = 1; lms_dly = 20; fir_dly = 1; fir_val = 16'sd321;
    bus.adapt_en_in = 1'b1; bus.nc_on_in = 1'b1;
    extra_q = '{4, 8, 12, 16, 20};
    do_frame(200, lat, e);
    exp_spk = fir_val;
    n_cmp++;
    if (vld_cnt !== 1 || lat !== exp_lat(1)) begin n_bad++; $display("FAIL ovr_frame valid_count=%0d lat=%0d want 1/%0d", vld_cnt, lat, exp_lat(1)); end
    n_cmp++;
    if (bus.overrun_count_out !== 8'd5) begin n_bad++; $display("FAIL ovr_count got %0d want 5", bus.overrun_count_out); end
    // A pulse landing exactly in OUT is still a drop.
    lms_dly = 1;
    extra_q = '{exp_lat(1)};
    do_frame(200, lat, e);
    tick(); tick();
    n_cmp++;
    if (bus.overrun_count_out !== 8'd6 || bus.busy_out !== 1'b0) begin
      n_bad++; $display("FAIL ovr_in_out count=%0d busy=%b want 6/0", bus.overrun_count_out, bus.busy_out);
    end
    exp_ovr = 6;
    lms_dly = 200;
    extra_q.delete();
    for (int k = 2; k <= 200; k += 2) extra_q.push_back(k);
    for (int f = 0; f < 4; f++) begin
      frame_len = exp_lat(1);
      do_frame(400, lat, e);
      exp_ovr = sat_add(exp_ovr, drops(frame_len));
      n_cmp++;
      if (int'(bus.overrun_count_out) !== exp_ovr) begin n_bad++; $display("FAIL ovr_sat_%0d got %0d want %0d", f, bus.overrun_count_out, exp_ovr); end
    end
    clear_sched();
  endtask

  task automatic test_timeout();
    int lat, e;
    clear_sched();
    lp_dly = 1; lms_dly = 0; fir_dly = 1; fir_val = 16'sd999;
    bus.adapt_en_in = 1'b1; bus.nc_on_in = 1'b1;
    do_frame(TO + 50, lat, e);
    exp_tmo = 1'b1;
    n_cmp++;
    if (e !== 3 + TO) begin n_bad++; $display("FAIL tmo_idle_offset got %0d want %0d", e, 3 + TO); end
    n_cmp++;
    if (bus.timeout_flag_out !== 1'b1 || vld_cnt !== 0) begin n_bad++; $display("FAIL tmo_flag flag=%b valid_count=%0d want 1/0", bus.timeout_flag_out, vld_cnt); end
    n_cmp++;
    if (bus.speaker_out !== exp_spk) begin n_bad++; $display("FAIL tmo_speaker_hold got %0d want %0d", bus.speaker_out, exp_spk); end
    lms_dly = 1; fir_val = 16'sd4321;
    do_frame(200, lat, e);
    exp_spk = fir_val;
    n_cmp++;
    if (bus.speaker_out !== exp_spk || lat !== 8) begin n_bad++; $display("FAIL tmo_recover speaker=%0d lat=%0d want %0d/8", bus.speaker_out, lat, exp_spk); end
    n_cmp++;
    if (bus.timeout_flag_out !== exp_tmo) begin n_bad++; $display("FAIL tmo_sticky got %b want 1", bus.timeout_flag_out); end
  endtask

  task automatic test_reset_mid();
    clear_sched();
    lp_dly = 1; lms_dly = 1; fir_dly = 0;
    bus.adapt_en_in = 1'b1; bus.nc_on_in = 1'b1;
    seq_code = 0; vld_cnt = 0; fir_seen = 1'b0;
    bus.sample_pulse_in = 1'b1;
    for (int i = 0; i < 50 && !fir_seen; i++) tick();
    n_cmp++;
    if (fir_seen !== 1'b1) begin n_bad++; $display("FAIL rstmid_reach_fir got %b want 1", fir_seen); end
    tick(); tick();
    rst_in = 1'b1;
    tick();
    n_cmp++;
    if ({bus.lp_start_out, bus.buf_write_out, bus.lms_start_out, bus.fir_start_out, bus.speaker_valid_out, bus.busy_out, bus.timeout_flag_out} !== 7'b0) begin
      n_bad++; $display("FAIL rstmid_flags got %b want 0000000", {bus.lp_start_out, bus.buf_write_out, bus.lms_start_out, bus.fir_start_out, bus.speaker_valid_out, bus.busy_out, bus.timeout_flag_out});
    end
    n_cmp++;
    if (bus.speaker_out !== '0 || bus.overrun_count_out !== '0) begin n_bad++; $display("FAIL rstmid_data speaker=%0d ovr=%0d want 0/0", bus.speaker_out, bus.overrun_count_out); end
    rst_in = 1'b0;
    exp_spk = '0; exp_ovr = 0; exp_tmo = 1'b0;
    seq_code = 0; vld_cnt = 0;
    bus.fir_done_in = 1'b1;
    bus.fir_sample_in = 16'sd777;
    tick(); tick(); tick();
    n_cmp++;
    if (vld_cnt !== 0 || seq_code !== 0 || bus.busy_out !== 1'b0 || bus.speaker_out !== '0) begin
      n_bad++; $display("FAIL rstmid_late_done valid_count=%0d events=%o busy=%b speaker=%0d want 0/0/0/0", vld_cnt, seq_code, bus.busy_out, bus.speaker_out);
    end
  endtask

  task automatic test_stray_done();
    int lat, e;
    clear_sched();
    seq_code = 0;
    tick();
    bus.lp_done_in = 1'b1; bus.lms_done_in = 1'b1; bus.fir_done_in = 1'b1;
    tick(); tick();
    n_cmp++;
    if (bus.busy_out !== 1'b0 || seq_code !== 0) begin n_bad++; $display("FAIL stray_idle busy=%b events=%o want 0/0", bus.busy_out, seq_code); end
    lp_dly = 3; lms_dly = 2; fir_dly = 2; fir_val = -16'sd1111;
    bus.adapt_en_in = 1'b1; bus.nc_on_in = 1'b1;
    lp_inj  = '{1};
    lms_inj = '{1, 2, 3, 4, 6};
    fir_inj = '{2, 6, 9};
    do_frame(200, lat, e);
    exp_spk = fir_val;
    n_cmp++;
    if (lat !== 12 || seq_code !== 'o12345) begin n_bad++; $display("FAIL stray_frame lat=%0d events=%o want 12/12345", lat, seq_code); end
    n_cmp++;
    if (bus.speaker_out !== exp_spk) begin n_bad++; $display("FAIL stray_speaker got %0d want %0d", bus.speaker_out, exp_spk); end
    clear_sched();
  endtask

  task automatic test_random();
    int lat, e, frame_len, a, b;
    bit adapt, nc;
    for (int f = 0; f < 25; f++) begin
      clear_sched();
      lp_dly = $urandom_range(1, 5); lms_dly = $urandom_range(1, 5); fir_dly = $urandom_range(1, 5);
      adapt = 1'($urandom); nc = 1'($urandom);
      fir_val = DW'($urandom);
      bus.adapt_en_in = adapt; bus.nc_on_in = nc;
      frame_len = exp_lat(adapt);
      a = $urandom_range(1, frame_len + 2);
      b = $urandom_range(1, frame_len + 2);
      if ($urandom_range(0, 1) == 1) extra_q.push_back(a);
      if (b != a) extra_q.push_back(b);
      do_frame(200, lat, e);
      exp_spk = nc ? fir_val : '0;
      exp_ovr = sat_add(exp_ovr, drops(frame_len));
      tick(); tick(); tick();
      n_cmp++;
      if (lat !== frame_len || seq_code !== (adapt ? 'o12345 : 'o1245)) begin
        n_bad++; $display("FAIL rand_%0d_frame lat=%0d events=%o want %0d/%o", f, lat, seq_code, frame_len, adapt ? 'o12345 : 'o1245);
      end
      n_cmp++;
      if (bus.speaker_out !== exp_spk) begin n_bad++; $display("FAIL rand_%0d_speaker got %0d want %0d", f, bus.speaker_out, exp_spk); end
      n_cmp++;
      if (int'(bus.overrun_count_out) !== exp_ovr || bus.busy_out !== 1'b0) begin
        n_bad++; $display("FAIL rand_%0d_ovr count=%0d busy=%b want %0d/0", f, bus.overrun_count_out, bus.busy_out, exp_ovr);
      end
    end
    clear_sched();
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    bus.sample_pulse_in = 1'b0; bus.nc_on_in = 1'b0; bus.adapt_en_in = 1'b0;
    bus.lp_done_in = 1'b0; bus.lms_done_in = 1'b0; bus.fir_done_in = 1'b0;
    bus.fir_sample_in = '0;
    lp_dly = 1; lms_dly = 1; fir_dly = 1; fir_val = '0;
    seq_code = 0; vld_cnt = 0; fir_seen = 1'b0;
    exp_spk = '0; exp_ovr = 0; exp_tmo = 1'b0;
    test_reset();
    test_adapt_on();
    test_adapt_off();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_stray_done();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
